fetch_sequencer: RTL and testbench

//  Controls the fetch stage: owns the program counter, drives the instruction-ROM address, and

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_pc_reg.sv | 29 ++
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch stage: FSM states, next-PC selects, widths and the NOP word.
package fetch_sequencer_pkg;
    localparam int LENGTH_INSTR_MEM = 10;
    localparam int WIDTH_INSTR_MEM  = 32;
    localparam int OPC_W            = 6;
    localparam logic [OPC_W-1:0] OP_NOP = 6'h20;

    localparam logic [WIDTH_INSTR_MEM-1:0] NOP_WORD = {OP_NOP, {(WIDTH_INSTR_MEM-OPC_W){1'b0}}};

    typedef enum logic [1:0] {
        FS_BOOT     = 2'd0,
        FS_RUN      = 2'd1,
        FS_REDIRECT = 2'd2,
        FS_HALT     = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2,
        PC_ZERO   = 2'd3
    } pc_sel_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux (hold / +1 / branch target / zero).
module fetch_pc_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W = LENGTH_INSTR_MEM
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      sel,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1
);
    // Natural PC_W-bit wrap gives the 2^PC_W-1 -> 0 rollover.
    assign pc_plus1 = pc + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else begin
            case (sel)
                PC_INC:    pc <= pc_plus1;
                PC_TARGET: pc <= target;
                PC_ZERO:   pc <= '0;
                default:   pc <= pc;
            endcase
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: boot bubbles, steady fetch, stalls, taken-branch redirect and halt.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W        = LENGTH_INSTR_MEM,
    parameter int INSTR_W     = WIDTH_INSTR_MEM,
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iStall,
    input  logic               iBr_taken,
    input  logic [PC_W-1:0]    iBr_dir,
    input  logic               iHalt,
    input  logic [INSTR_W-1:0] iInstr,
    output logic [PC_W-1:0]    oPc,
    output logic [INSTR_W-1:0] oInstr,
    output logic               oInstr_valid,
    output logic [PC_W-1:0]    oNew_pc,
    output logic               oFlush,
    output logic               oHalted,
    output logic [CNT_W-1:0]   oFetch_cnt
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [INSTR_W-1:0] NOP_W = {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};

    fetch_state_t  state;
    pc_sel_t       pc_sel;
    logic [BW-1:0] boot_cnt;
    logic [PC_W-1:0] pc_plus1;

    // Next-PC select mirrors the priority used by the FSM below.
    always_comb begin
        pc_sel = PC_HOLD;
        case (state)
            FS_BOOT:     pc_sel = PC_ZERO;
            FS_RUN: begin
                if (iBr_taken)           pc_sel = PC_TARGET;
                else if (iStall || iHalt) pc_sel = PC_HOLD;
                else                     pc_sel = PC_INC;
            end
            FS_REDIRECT: pc_sel = PC_INC;
            default:     pc_sel = PC_HOLD;
        endcase
    end

    fetch_pc_reg #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .sel      (pc_sel),
        .target   (iBr_dir),
        .pc       (oPc),
        .pc_plus1 (pc_plus1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FS_BOOT;
            boot_cnt     <= '0;
            oInstr       <= NOP_W;
            oInstr_valid <= 1'b0;
            oNew_pc      <= PC_W'(1);
            oFlush       <= 1'b0;
            oHalted      <= 1'b0;
            oFetch_cnt   <= '0;
        end else begin
            oFlush <= 1'b0;
            case (state)
                FS_BOOT: begin
                    if (boot_cnt == BOOT_LAST) state <= FS_RUN;
                    else                       boot_cnt <= boot_cnt + 1'b1;
                end
                FS_RUN: begin
                    if (iBr_taken) begin
                        oInstr       <= NOP_W;
                        oInstr_valid <= 1'b0;
                        oFlush       <= 1'b1;
                        state        <= FS_REDIRECT;
                    end else if (iStall) begin
                        state <= FS_RUN;
                    end else if (iHalt) begin
                        oInstr       <= NOP_W;
                        oInstr_valid <= 1'b0;
                        oHalted      <= 1'b1;
                        state        <= FS_HALT;
                    end else begin
                        oInstr       <= iInstr;
                        oInstr_valid <= 1'b1;
                        oNew_pc      <= pc_plus1;
                        oFetch_cnt   <= oFetch_cnt + 1'b1;
                    end
                end
                // The bubble was already emitted on the branch edge; fetch the target unconditionally.
                FS_REDIRECT: begin
                    oInstr       <= iInstr;
                    oInstr_valid <= 1'b1;
                    oNew_pc      <= pc_plus1;
                    oFetch_cnt   <= oFetch_cnt + 1'b1;
                    state        <= FS_RUN;
                end
                default: state <= FS_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized checks of fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;
    localparam logic [31:0] NOP = 32'h8000_0000;

    logic        clk, reset, iStall, iBr_taken, iHalt;
    logic [9:0]  iBr_dir, oPc, oNew_pc;
    logic [31:0] iInstr, oInstr;
    logic        oInstr_valid, oFlush, oHalted;
    logic [15:0] oFetch_cnt;

    int ncmp = 0;
    int nerr = 0;

    // Model state
    int unsigned m_boot;
    bit          m_redir, m_halt, m_valid, m_flush;
    logic [9:0]  m_pc, m_npc;
    logic [31:0] m_instr;
    logic [15:0] m_cnt;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .iStall(iStall), .iBr_taken(iBr_taken),
        .iBr_dir(iBr_dir), .iHalt(iHalt), .iInstr(iInstr), .oPc(oPc),
        .oInstr(oInstr), .oInstr_valid(oInstr_valid), .oNew_pc(oNew_pc),
        .oFlush(oFlush), .oHalted(oHalted), .oFetch_cnt(oFetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [9:0] a);
        return 32'h100 + {22'b0, a};
    endfunction

    assign iInstr = rom(oPc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc",      {22'b0, oPc},        {22'b0, m_pc});
        chk("instr",   oInstr,              m_instr);
        chk("valid",   {31'b0, oInstr_valid}, {31'b0, m_valid});
        chk("new_pc",  {22'b0, oNew_pc},    {22'b0, m_npc});
        chk("flush",   {31'b0, oFlush},     {31'b0, m_flush});
        chk("halted",  {31'b0, oHalted},    {31'b0, m_halt});
        chk("cnt",     {16'b0, oFetch_cnt}, {16'b0, m_cnt});
    endtask

    task automatic model_reset();
        m_boot = 2; m_redir = 0; m_halt = 0; m_valid = 0; m_flush = 0;
        m_pc = 0; m_npc = 1; m_instr = NOP; m_cnt = 0;
    endtask

    task automatic model_fetch();
        m_instr = rom(m_pc);
        m_valid = 1;
        m_pc    = m_pc + 10'd1;
        m_npc   = m_pc;
        m_cnt   = m_cnt + 16'd1;
    endtask

    task automatic model_step(input bit s, input bit b, input logic [9:0] d, input bit h);
        m_flush = 0;
        if (m_boot > 0)   m_boot--;
        else if (m_halt) begin end
        else if (m_redir) begin m_redir = 0; model_fetch(); end
        else if (b) begin
            m_pc = d; m_instr = NOP; m_valid = 0; m_flush = 1; m_redir = 1;
        end
        else if (s) begin end
        else if (h) begin m_instr = NOP; m_valid = 0; m_halt = 1; end
        else model_fetch();
    endtask

    // Drive at negedge, check 1 time unit after the posedge, return at the next negedge.
    task automatic cycle(input bit s, input bit b, input logic [9:0] d, input bit h);
        iStall = s; iBr_taken = b; iBr_dir = d; iHalt = h;
        @(posedge clk);
        model_step(s, b, d, h);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; iStall = 0; iBr_taken = 0; iBr_dir = 0; iHalt = 0;
        #1;
        model_reset();
        check_all();
        chk("reset_new_pc", {22'b0, oNew_pc}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Boot: branch and stall ignored, no valid until the third edge.
        cycle(1, 1, 10'h55, 0);
        cycle(0, 0, 0, 1);
        chk("boot_valid", {31'b0, oInstr_valid}, 32'd0);
        chk("boot_pc", {22'b0, oPc}, 32'd0);
        cycle(0, 0, 0, 0);
        chk("first_instr", oInstr, 32'h100);
        chk("first_new_pc", {22'b0, oNew_pc}, 32'd1);
        cycle(0, 0, 0, 0);
        chk("second_instr", oInstr, 32'h101);
        cycle(0, 0, 0, 0);
        chk("third_instr", oInstr, 32'h102);
        chk("cnt_three", {16'b0, oFetch_cnt}, 32'd3);

        // Stall for two cycles at pc 5.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("pc_at_5", {22'b0, oPc}, 32'd5);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("stall_pc", {22'b0, oPc}, 32'd5);
        chk("stall_cnt", {16'b0, oFetch_cnt}, 32'd5);
        cycle(0, 0, 0, 0);
        chk("resume_instr", oInstr, 32'h105);

        // Taken branch at pc 6.
        cycle(0, 1, 10'h26, 0);
        chk("br_flush", {31'b0, oFlush}, 32'd1);
        chk("br_valid", {31'b0, oInstr_valid}, 32'd0);
        cycle(0, 0, 0, 0);
        chk("redir_flush", {31'b0, oFlush}, 32'd0);
        chk("redir_instr", oInstr, 32'h126);
        chk("redir_new_pc", {22'b0, oNew_pc}, 32'h27);

        // Branch wins over stall; redirect ignores a second branch.
        cycle(1, 1, 10'h40, 0);
        chk("br_over_stall_pc", {22'b0, oPc}, 32'h40);
        cycle(1, 1, 10'h77, 1);
        chk("redir_ignores", oInstr, 32'h140);

        // Reset asserted during REDIRECT takes effect without a clock edge.
        cycle(0, 1, 10'h10, 0);
        do_reset();

        // Halt at the top of the address space.
        repeat (2) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 10'h3FD, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("pc_3ff", {22'b0, oPc}, 32'h3FF);
        cycle(0, 0, 0, 1);
        repeat (20) cycle(0, 0, 0, 0);
        chk("halted_held", {31'b0, oHalted}, 32'd1);
        chk("halt_valid", {31'b0, oInstr_valid}, 32'd0);

        // Without halt the PC wraps past 0x3FF.
        do_reset();
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 1, 10'h3FE, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("wrap_pc", {22'b0, oPc}, 32'd0);
        chk("wrap_new_pc", {22'b0, oNew_pc}, 32'd0);
        chk("wrap_instr", oInstr, 32'h4FF);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            else cycle($urandom_range(3) == 0, $urandom_range(9) == 0,
                       10'($urandom_range(1023)), $urandom_range(59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
